// File: rtl/display_scan_mux.sv
// N-digit time-multiplexed display scanner: one-hot digit select with per-digit
// dwell, blanking dead-time between digits, enable mask, select polarity and frame strobe.
module display_scan_mux #(
    parameter int NUM_DIGITS     = 2,
    parameter int DIGIT_W        = 4,
    parameter int DWELL_CYCLES   = 10000,
    parameter int BLANK_CYCLES   = 16,
    parameter bit SEL_ACTIVE_LOW = 1'b0,
    localparam int IDX_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_DIGITS*DIGIT_W-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]           digit_en,
    output logic [NUM_DIGITS-1:0]           sel,
    output logic [DIGIT_W-1:0]              digit_out,
    output logic [IDX_W-1:0]                digit_idx,
    output logic                            frame_tick
);

    localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0]      DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] SEL_OFF    = {NUM_DIGITS{SEL_ACTIVE_LOW}};

    if (NUM_DIGITS < 1) begin : g_bad_num_digits
        $error("display_scan_mux: NUM_DIGITS must be >= 1");
    end
    if (DWELL_CYCLES < 1) begin : g_bad_dwell
        $error("display_scan_mux: DWELL_CYCLES must be >= 1");
    end

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DWELL = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;
    logic [DIGIT_W-1:0]      digit_q, digit_d;
    logic                    tick_q, tick_d;
    logic                    enter_dwell;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can leave one unassigned and infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        idx_d       = idx_q;
        sel_d       = sel_q;
        tick_d      = 1'b0;
        enter_dwell = 1'b0;

        case (state_q)
            ST_BLANK: begin
                if (BLANK_CYCLES == 0 || cnt_q == BLANK_LAST) begin
                    enter_dwell = 1'b1;
                end
            end
            ST_DWELL: begin
                if (cnt_q == DWELL_LAST) begin
                    idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                    tick_d = (idx_q == IDX_LAST);
                    cnt_d  = '0;
                    if (BLANK_CYCLES == 0) begin
                        enter_dwell = 1'b1;
                    end else begin
                        state_d = ST_BLANK;
                        sel_d   = SEL_OFF;
                    end
                end
            end
            default: begin
                state_d = ST_BLANK;
                sel_d   = SEL_OFF;
            end
        endcase

        // The enable bit is captured into the select register here and held for the whole dwell.
        if (enter_dwell) begin
            state_d = ST_DWELL;
            cnt_d   = '0;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                sel_d[k] = (idx_d == IDX_W'(k)) && digit_en[k];
            end
            sel_d = sel_d ^ SEL_OFF;
        end

        // Indexed by the next index so the value lines up with sel on the same edge.
        digit_d = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_d == IDX_W'(k)) begin
                digit_d = digits_in[k*DIGIT_W +: DIGIT_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q <= ST_BLANK;
            cnt_q   <= '0;
            idx_q   <= '0;
            sel_q   <= SEL_OFF;
            digit_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            digit_q <= digit_d;
            tick_q  <= tick_d;
        end
    end

    assign sel        = sel_q;
    assign digit_out  = digit_q;
    assign digit_idx  = idx_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// Scoreboard bench for display_scan_mux: three configurations (4-digit blanked,
// 2-digit active-low unblanked, single digit), expectations from scan timing.
module tb_display_scan_mux;

    typedef struct {
        int         u;
        int         k;
        logic [3:0] sel;
        logic [3:0] dout;
        logic [1:0] idx;
        logic       tick;
    } exp_t;

    localparam int   CFG_N  [3] = '{4, 2, 1};
    localparam int   CFG_D  [3] = '{5, 3, 4};
    localparam int   CFG_B  [3] = '{2, 0, 1};
    localparam logic CFG_LO [3] = '{1'b0, 1'b1, 1'b0};

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_v    [3];
    logic [15:0] digits_v [3];
    logic [3:0]  en_v     [3];

    logic [3:0]  sel_a;  logic [3:0] dout_a;  logic [1:0] idx_a;  logic tick_a;
    logic [1:0]  sel_b;  logic [3:0] dout_b;  logic       idx_b;  logic tick_b;
    logic        sel_c;  logic [3:0] dout_c;  logic       idx_c;  logic tick_c;

    display_scan_mux #(.NUM_DIGITS(CFG_N[0]), .DIGIT_W(4), .DWELL_CYCLES(CFG_D[0]),
                       .BLANK_CYCLES(CFG_B[0]), .SEL_ACTIVE_LOW(CFG_LO[0])) u_a (
        .clk(clk), .reset(rst_v[0]), .digits_in(digits_v[0]), .digit_en(en_v[0]),
        .sel(sel_a), .digit_out(dout_a), .digit_idx(idx_a), .frame_tick(tick_a));

    display_scan_mux #(.NUM_DIGITS(CFG_N[1]), .DIGIT_W(4), .DWELL_CYCLES(CFG_D[1]),
                       .BLANK_CYCLES(CFG_B[1]), .SEL_ACTIVE_LOW(CFG_LO[1])) u_b (
        .clk(clk), .reset(rst_v[1]), .digits_in(digits_v[1][7:0]), .digit_en(en_v[1][1:0]),
        .sel(sel_b), .digit_out(dout_b), .digit_idx(idx_b), .frame_tick(tick_b));

    display_scan_mux #(.NUM_DIGITS(CFG_N[2]), .DIGIT_W(4), .DWELL_CYCLES(CFG_D[2]),
                       .BLANK_CYCLES(CFG_B[2]), .SEL_ACTIVE_LOW(CFG_LO[2])) u_c (
        .clk(clk), .reset(rst_v[2]), .digits_in(digits_v[2][3:0]), .digit_en(en_v[2][0:0]),
        .sel(sel_c), .digit_out(dout_c), .digit_idx(idx_c), .frame_tick(tick_c));

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   k_cnt  = 0;
    logic lat    = 1'b0;
    int   ticks  = 0;
    int   active_cycles = 0;
    int   zero_sel_cycles = 0;

    function automatic exp_t actual(input int u);
        exp_t a;
        a.u = u;
        a.k = 0;
        case (u)
            0: begin a.sel = sel_a; a.dout = dout_a; a.idx = idx_a; a.tick = tick_a; end
            1: begin a.sel = {2'b00, sel_b}; a.dout = dout_b; a.idx = {1'b0, idx_b}; a.tick = tick_b; end
            default: begin a.sel = {3'b000, sel_c}; a.dout = dout_c; a.idx = {1'b0, idx_c}; a.tick = tick_c; end
        endcase
        return a;
    endfunction

    function automatic logic [3:0] sel_off(input int u);
        logic [3:0] mask;
        mask = 4'((1 << CFG_N[u]) - 1);
        return CFG_LO[u] ? mask : 4'b0000;
    endfunction

    task automatic check(input string name, input int u, input int k,
                         input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s unit=%0d k=%0d actual=%0h required=%0h", name, u, k, act, req);
        end
    endtask

    // One clock edge for unit u; pushes what the outputs must be after that edge.
    task automatic step(input int u);
        exp_t       e;
        exp_t       a;
        int         n, d, b, t, p, j, per;
        logic [3:0] off;
        n   = CFG_N[u];
        d   = CFG_D[u];
        b   = CFG_B[u];
        per = d + b;
        off = sel_off(u);
        @(posedge clk);
        #1;
        e.u    = u;
        e.sel  = off;
        e.dout = 4'h0;
        e.idx  = 2'd0;
        e.tick = 1'b0;
        if (rst_v[u]) begin
            k_cnt = 0;
        end else begin
            k_cnt++;
            t = k_cnt - ((b > 0) ? b : 1);
            if (t >= 0) begin
                p = t % per;
                j = (t / per) % n;
                if (p < d) begin
                    if (p == 0) lat = en_v[u][j];
                    e.idx = 2'(j);
                    if (lat) e.sel = off ^ (4'b0001 << j);
                end else begin
                    e.idx = 2'((j + 1) % n);
                end
                e.tick = (t >= d) && ((t - d) % per == 0) && (((t - d) / per) % n == n - 1);
            end
            e.dout = digits_v[u][int'(e.idx)*4 +: 4];
        end
        e.k = k_cnt;
        q.push_back(e);
        a = actual(u);
        if (a.tick === 1'b1) ticks++;
        if (a.sel !== off) active_cycles++;
        if (u == 1 && a.sel[1:0] == 2'b00) zero_sel_cycles++;
    endtask

    task automatic do_reset(input int u, input int cycles);
        rst_v[u] = 1'b1;
        repeat (cycles) step(u);
        rst_v[u] = 1'b0;
    endtask

    // Monitor: every output cycle is a transaction; compare against the queued expectation.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                a = actual(e.u);
                check("sel",        e.u, e.k, 32'(a.sel),  32'(e.sel));
                check("digit_out",  e.u, e.k, 32'(a.dout), 32'(e.dout));
                check("digit_idx",  e.u, e.k, 32'(a.idx),  32'(e.idx));
                check("frame_tick", e.u, e.k, 32'(a.tick), 32'(e.tick));
            end
        end
    end

    initial begin
        exp_t a;
        for (int i = 0; i < 3; i++) begin
            rst_v[i]    = 1'b1;
            digits_v[i] = 16'h0000;
            en_v[i]     = 4'h0;
        end
        repeat (2) @(posedge clk);
        #1;

        // 4 digits, D=5, B=2: basic scan plus a digit-1 value change mid-dwell.
        digits_v[0] = 16'h4321;
        en_v[0]     = 4'hF;
        do_reset(0, 2);
        ticks = 0;
        for (int i = 0; i < 60; i++) begin
            if (k_cnt == 10) digits_v[0] = 16'h4391;
            step(0);
        end
        check("frame_ticks_basic", 0, k_cnt, ticks, 2);

        // Reset asserted during the dwell of digit 2, then the scan restarts from blank.
        digits_v[0] = 16'h4321;
        do_reset(0, 1);
        repeat (18) step(0);
        a = actual(0);
        check("idx_before_reset", 0, k_cnt, 32'(a.idx), 2);
        do_reset(0, 1);
        repeat (30) step(0);

        // Enable mask 1010, with digit 1 disabled mid-dwell and restored later.
        en_v[0] = 4'b1010;
        do_reset(0, 1);
        ticks = 0;
        active_cycles = 0;
        for (int i = 0; i < 60; i++) begin
            if (k_cnt == 10) en_v[0] = 4'b1000;
            if (k_cnt == 40) en_v[0] = 4'b1010;
            step(0);
        end
        check("frame_ticks_masked", 0, k_cnt, ticks, 2);
        check("active_cycles_masked", 0, k_cnt, active_cycles, 15);
        do_reset(0, 1);

        // 2 digits, D=3, no blanking, active-low selects.
        digits_v[1] = 16'h005A;
        en_v[1]     = 4'h3;
        do_reset(1, 2);
        ticks = 0;
        zero_sel_cycles = 0;
        repeat (30) step(1);
        check("frame_ticks_noblank", 1, k_cnt, ticks, 4);
        check("never_both_selected", 1, k_cnt, zero_sel_cycles, 0);
        do_reset(1, 1);

        // Single digit, D=4, B=1; then all digits disabled.
        digits_v[2] = 16'h0007;
        en_v[2]     = 4'h1;
        do_reset(2, 1);
        ticks = 0;
        repeat (25) step(2);
        check("frame_ticks_single", 2, k_cnt, ticks, 5);
        en_v[2] = 4'h0;
        active_cycles = 0;
        repeat (12) step(2);
        check("active_cycles_disabled", 2, k_cnt, active_cycles, 0);

        @(negedge clk);
        #1;
        check("scoreboard_drained", 0, k_cnt, q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
